// File: rtl/usb_tx_if.sv
// Request/status and packet-buffer read signals between a host-side controller and usb_tx.
// append_crc exists only when USB_TX_CRC16_EN is defined.
interface usb_tx_if #(
  parameter int BUFFER_ADDRESS_WIDTH = 8
);
  logic                            start;
  logic [10:0]                     length;
`ifdef USB_TX_CRC16_EN
  logic                            append_crc;
`endif
  logic [BUFFER_ADDRESS_WIDTH-1:0] buffer_address;
  logic [31:0]                     buffer_read_value;
  logic                            busy;
  logic                            done;

`ifdef USB_TX_CRC16_EN
  modport master (output start, length, append_crc, buffer_read_value,
                  input  buffer_address, busy, done);
  modport slave  (input  start, length, append_crc, buffer_read_value,
                  output buffer_address, busy, done);
`else
  modport master (output start, length, buffer_read_value,
                  input  buffer_address, busy, done);
  modport slave  (input  start, length, buffer_read_value,
                  output buffer_address, busy, done);
`endif
endinterface

// File: rtl/usb_tx.sv
// Full-speed USB packet transmitter: SYNC, NRZI/bit-stuffed payload, optional CRC16, EOP.
// Optional feature macro: USB_TX_CRC16_EN (append_crc port and CRC16 generator).
module usb_tx #(
  parameter int CLOCKS_PER_BIT       = 4,
  parameter int BUFFER_ADDRESS_WIDTH = 8
) (
  input  logic    clk48,
  input  logic    reset,
  usb_tx_if.slave bus,
  output logic    usb_oe,
  output logic    usb_d_p_out,
  output logic    usb_d_n_out
);
  localparam int TW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_CRC, S_EOP_SE0, S_EOP_J} state_t;

  state_t                          state_q, state_d;
  logic [TW-1:0]                   tick_q, tick_d;
  logic [3:0]                      bit_cnt_q, bit_cnt_d;
  logic [10:0]                     byte_cnt_q, byte_cnt_d;
  logic [10:0]                     len_q, len_d;
  logic [15:0]                     shift_q, shift_d;
  logic [31:0]                     word_q, word_d;
  logic [2:0]                      ones_q, ones_d;
  logic                            nrzi_q, nrzi_d;
  logic [BUFFER_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                            issue_q, issue_d;
  logic                            fetch_q, fetch_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            oe_q, oe_d;
  logic                            dp_q, dp_d;
  logic                            dn_q, dn_d;
`ifdef USB_TX_CRC16_EN
  logic [15:0]                     crc_q, crc_d;
  logic                            crc_en_q, crc_en_d;
`endif

  logic [7:0] cur_byte;
  logic       send_bit;
  logic       bit_val;
  logic       enter_tail;

  assign cur_byte = word_q[{byte_cnt_q[1:0], 3'b000} +: 8];

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    shift_d    = shift_q;
    word_d     = word_q;
    ones_d     = ones_q;
    nrzi_d     = nrzi_q;
    addr_d     = addr_q;
    issue_d    = 1'b0;
    fetch_d    = issue_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    oe_d       = oe_q;
    dp_d       = dp_q;
    dn_d       = dn_q;
`ifdef USB_TX_CRC16_EN
    crc_d      = crc_q;
    crc_en_d   = crc_en_q;
`endif
    send_bit   = 1'b0;
    bit_val    = 1'b0;
    enter_tail = 1'b0;

    // The buffer answers one cycle after the address is presented.
    if (fetch_q) word_d = bus.buffer_read_value;

    if (state_q == S_IDLE) begin
      if (bus.start) begin
        // First SYNC bit (a 0) goes out now: J toggles to K.
        state_d    = S_SYNC;
        len_d      = bus.length;
        tick_d     = '0;
        bit_cnt_d  = 4'd1;
        byte_cnt_d = '0;
        shift_d    = 16'h0040;
        ones_d     = 3'd0;
        nrzi_d     = 1'b0;
        dp_d       = 1'b0;
        dn_d       = 1'b1;
        oe_d       = 1'b1;
        busy_d     = 1'b1;
        addr_d     = '0;
        issue_d    = 1'b1;
`ifdef USB_TX_CRC16_EN
        crc_d      = 16'hFFFF;
        crc_en_d   = bus.append_crc;
`endif
      end
    end else if (tick_q != TICK_LAST) begin
      tick_d = tick_q + 1'b1;
    end else begin
      tick_d = '0;
      if (ones_q == 3'd6) begin
        send_bit = 1'b1;
      end else begin
        case (state_q)
          S_SYNC: begin
            send_bit  = 1'b1;
            bit_val   = shift_q[0];
            shift_d   = {1'b0, shift_q[15:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (len_q != 11'd0) state_d = S_DATA;
              else                enter_tail = 1'b1;
            end
          end
          S_DATA: begin
            send_bit = 1'b1;
            if (bit_cnt_q == 4'd0) begin
              bit_val = cur_byte[0];
              shift_d = {9'd0, cur_byte[7:1]};
              // Last byte of this word is now held in shift_q, so word_q may be refilled.
              if (byte_cnt_q[1:0] == 2'd3 && (byte_cnt_q + 11'd1) != len_q) begin
                addr_d  = addr_q + 1'b1;
                issue_d = 1'b1;
              end
            end else begin
              bit_val = shift_q[0];
              shift_d = {1'b0, shift_q[15:1]};
            end
`ifdef USB_TX_CRC16_EN
            if (byte_cnt_q != 11'd0)
              crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ bit_val) ? 16'hA001 : 16'h0000);
`endif
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d  = 4'd0;
              byte_cnt_d = byte_cnt_q + 11'd1;
              if ((byte_cnt_q + 11'd1) == len_q) enter_tail = 1'b1;
            end
          end
`ifdef USB_TX_CRC16_EN
          S_CRC: begin
            send_bit  = 1'b1;
            bit_val   = shift_q[0];
            shift_d   = {1'b0, shift_q[15:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              bit_cnt_d = 4'd0;
              state_d   = S_EOP_SE0;
            end
          end
`endif
          S_EOP_SE0: begin
            dp_d      = 1'b0;
            dn_d      = 1'b0;
            nrzi_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd1) begin
              bit_cnt_d = 4'd0;
              state_d   = S_EOP_J;
            end
          end
          S_EOP_J: begin
            if (bit_cnt_q == 4'd0) begin
              dp_d      = 1'b1;
              dn_d      = 1'b0;
              bit_cnt_d = 4'd1;
            end else begin
              bit_cnt_d = 4'd0;
              state_d   = S_IDLE;
              busy_d    = 1'b0;
              oe_d      = 1'b0;
              done_d    = 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase

        if (enter_tail) begin
          bit_cnt_d = 4'd0;
          state_d   = S_EOP_SE0;
`ifdef USB_TX_CRC16_EN
          if (crc_en_q) begin
            state_d = S_CRC;
            shift_d = ~crc_d;
          end
`endif
        end
      end

      if (send_bit) begin
        nrzi_d = bit_val ? nrzi_q : ~nrzi_q;
        ones_d = bit_val ? (ones_q + 3'd1) : 3'd0;
        dp_d   = nrzi_d;
        dn_d   = ~nrzi_d;
      end
    end
  end

  always_ff @(posedge clk48) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      ones_q     <= '0;
      nrzi_q     <= 1'b1;
      addr_q     <= '0;
      issue_q    <= 1'b0;
      fetch_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      oe_q       <= 1'b0;
      dp_q       <= 1'b1;
      dn_q       <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_q      <= 16'hFFFF;
      crc_en_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      ones_q     <= ones_d;
      nrzi_q     <= nrzi_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      fetch_q    <= fetch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      oe_q       <= oe_d;
      dp_q       <= dp_d;
      dn_q       <= dn_d;
`ifdef USB_TX_CRC16_EN
      crc_q      <= crc_d;
      crc_en_q   <= crc_en_d;
`endif
    end
  end

  assign bus.buffer_address = addr_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign usb_oe             = oe_q;
  assign usb_d_p_out        = dp_q;
  assign usb_d_n_out        = dn_q;
endmodule

// File: tb/tb_usb_tx.sv
// Directed and randomized checks of usb_tx against a bit-stream model of the USB line.
module tb_usb_tx;
  localparam int CPB = 4;

  logic clk48;
  logic reset;
  logic usb_oe, usb_d_p_out, usb_d_n_out;
  logic [31:0] mem [0:255];

  int n_pass  = 0;
  int n_total = 0;

  usb_tx_if #(.BUFFER_ADDRESS_WIDTH(8)) bus ();

  usb_tx #(.CLOCKS_PER_BIT(CPB), .BUFFER_ADDRESS_WIDTH(8)) dut (
    .clk48       (clk48),
    .reset       (reset),
    .bus         (bus),
    .usb_oe      (usb_oe),
    .usb_d_p_out (usb_d_p_out),
    .usb_d_n_out (usb_d_n_out)
  );

  initial clk48 = 1'b0;
  always #10 clk48 = ~clk48;

  // Packet buffer with a registered read port.
  always @(posedge clk48) bus.buffer_read_value <= mem[bus.buffer_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] line_char();
    case ({usb_d_p_out, usb_d_n_out})
      2'b10:   return "J";
      2'b01:   return "K";
      2'b00:   return "0";
      default: return "X";
    endcase
  endfunction

  // Line-state string for one packet: J/K per bit period, "0" for SE0.
  function automatic string model(input logic [7:0] data[$], input bit crc);
    bit    raw[$];
    bit    line_bits[$];
    string s;
    int    ones;
    bit    lvl;
    logic [15:0] c;
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    foreach (data[n]) for (int i = 0; i < 8; i++) raw.push_back(data[n][i]);
    if (crc) begin
      c = 16'hFFFF;
      for (int n = 1; n < data.size(); n++) begin
        c = c ^ {8'h00, data[n]};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      c = ~c;
      for (int i = 0; i < 16; i++) raw.push_back(c[i]);
    end
    ones = 0;
    foreach (raw[i]) begin
      line_bits.push_back(raw[i]);
      if (raw[i]) begin
        ones++;
        if (ones == 6) begin
          line_bits.push_back(1'b0);
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
    lvl = 1'b1;
    s = "";
    foreach (line_bits[i]) begin
      if (!line_bits[i]) lvl = ~lvl;
      s = {s, lvl ? "J" : "K"};
    end
    return {s, "00J"};
  endfunction

  task automatic load(input logic [7:0] data[$]);
    for (int w = 0; w < 256; w++) mem[w] = 32'h0;
    foreach (data[n]) mem[n / 4][8 * (n % 4) +: 8] = data[n];
  endtask

  // Starts a packet and checks every cycle through the done pulse.
  task automatic run_packet(input string tag, input string exp, input int len, input int inject_k);
    int cycles;
    @(negedge clk48);
    bus.start  = 1'b1;
    bus.length = 11'(len);
    @(negedge clk48);
    bus.start = 1'b0;
    cycles = exp.len() * CPB;
    for (int k = 0; k < cycles; k++) begin
      chk({tag, "/line"}, {24'd0, line_char()}, {24'd0, exp[k / CPB]});
      chk({tag, "/oe"},   {31'd0, usb_oe},   32'd1);
      chk({tag, "/busy"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, "/done"}, {31'd0, bus.done}, 32'd0);
      if (k == 0) chk({tag, "/addr0"}, {24'd0, bus.buffer_address}, 32'd0);
      if (k == inject_k) begin
        bus.start  = 1'b1;
        bus.length = 11'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk48);
    end
    bus.start = 1'b0;
    chk({tag, "/done_pulse"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "/busy_end"},   {31'd0, bus.busy}, 32'd0);
    chk({tag, "/oe_end"},     {31'd0, usb_oe},   32'd0);
    chk({tag, "/line_end"},   {24'd0, line_char()}, {24'd0, 8'("J")});
    @(negedge clk48);
    chk({tag, "/done_once"},  {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    logic [7:0] pl[$];
    bit         crc;
    int         len;
    string      exp;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.length = 11'd0;
`ifdef USB_TX_CRC16_EN
    bus.append_crc = 1'b0;
`endif
    for (int w = 0; w < 256; w++) mem[w] = 32'h0;
    repeat (3) @(negedge clk48);
    reset = 1'b0;
    @(negedge clk48);
    chk("reset/busy", {31'd0, bus.busy}, 32'd0);
    chk("reset/done", {31'd0, bus.done}, 32'd0);
    chk("reset/oe",   {31'd0, usb_oe},   32'd0);
    chk("reset/line", {24'd0, line_char()}, {24'd0, 8'("J")});
    chk("reset/addr", {24'd0, bus.buffer_address}, 32'd0);

    // ACK handshake
    mem[0] = 32'h000000D2;
    run_packet("ack", "KJKJKJKKJJKJJKKK00J", 1, -1);

    // Stuff bit after the fifth data 1
    mem[0] = 32'h000000FF;
    run_packet("stuff", {"KJKJKJKK", "KKKKKJJJJ", "00J"}, 1, -1);

`ifdef USB_TX_CRC16_EN
    mem[0] = 32'h000000C3;
    bus.append_crc = 1'b1;
    run_packet("crc1", {"KJKJKJKK", "KKJKJKKK", "JKJKJKJKJKJKJKJK", "00J"}, 1, -1);
    bus.append_crc = 1'b0;
`endif

    // Two-word payload with a start request ignored mid-packet
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    load(pl);
    run_packet("multi", model(pl, 1'b0), 5, 40);
    chk("multi/addr1", {24'd0, bus.buffer_address}, 32'd1);

    // Zero-length packet: SYNC then EOP
    run_packet("len0", "KJKJKJKK00J", 0, -1);

    // Reset during DATA
    pl = '{8'hA5, 8'h5A, 8'h0F, 8'hF0};
    load(pl);
    @(negedge clk48);
    bus.start  = 1'b1;
    bus.length = 11'd4;
    @(negedge clk48);
    bus.start = 1'b0;
    repeat (8 * CPB + 10) @(negedge clk48);
    reset = 1'b1;
    @(negedge clk48);
    reset = 1'b0;
    chk("rst_mid/oe",   {31'd0, usb_oe},   32'd0);
    chk("rst_mid/busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid/done", {31'd0, bus.done}, 32'd0);
    chk("rst_mid/line", {24'd0, line_char()}, {24'd0, 8'("J")});
    chk("rst_mid/addr", {24'd0, bus.buffer_address}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk48);
      chk("rst_mid/no_done", {31'd0, bus.done}, 32'd0);
    end
    mem[0] = 32'h000000D2;
    run_packet("ack_after_rst", "KJKJKJKKJJKJJKKK00J", 1, -1);

    // Randomized payloads, biased toward 0xFF to exercise stuffing
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(0, 10);
      pl.delete();
      for (int n = 0; n < len; n++)
        pl.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      crc = 1'b0;
`ifdef USB_TX_CRC16_EN
      crc = 1'($urandom_range(0, 1));
      bus.append_crc = crc;
`endif
      load(pl);
      exp = model(pl, crc);
      run_packet($sformatf("rand%0d_len%0d", t, len), exp, len, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
